// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the byte-serial memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B     = 2'd0;
  localparam logic [1:0] SZ_H     = 2'd1;
  localparam logic [1:0] IO_FIELD = 2'b11;

  // Illegal size code 3 falls into the word case.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the 8-bit RAM/IO bus between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_done_o,
  output logic [31:0]       d_rdata_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state;
  logic              owner_d;
  logic [2:0]        cnt;
  logic [2:0]        nbytes_q;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_next;
  logic              rdy_q;
  logic              mem_wr_q;
  logic              d_go;
  logic              i_go;
  logic              io_rd;

  // A requester whose done pulse is showing is not re-granted in that cycle.
  assign d_go   = d_req_i && !d_done_o;
  assign i_go   = if_req_i && !if_done_o && !d_go;
  assign mem_wr = mem_wr_q && rdy;
  assign io_rd  = (state == ST_RD) && owner_d && (base[IO_BIT+1:IO_BIT] == IO_FIELD);

  // Byte k arrives one cycle after its address, i.e. while cnt == k+2.
  always_comb begin
    asm_next = asm_q;
    case (cnt)
      3'd2:    asm_next[7:0]   = mem_din;
      3'd3:    asm_next[15:8]  = mem_din;
      3'd4:    asm_next[23:16] = mem_din;
      3'd5:    asm_next[31:24] = mem_din;
      default: asm_next = asm_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner_d   <= 1'b0;
      cnt       <= 3'd0;
      nbytes_q  <= 3'd0;
      base      <= '0;
      wdata_q   <= 32'd0;
      asm_q     <= 32'd0;
      rdy_q     <= 1'b1;
      mem_wr_q  <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= 8'd0;
      if_done_o <= 1'b0;
      if_data_o <= 32'd0;
      d_done_o  <= 1'b0;
      d_rdata_o <= 32'd0;
    end else begin
      if_done_o <= 1'b0;
      d_done_o  <= 1'b0;
      rdy_q     <= rdy;
      if (rdy) begin
        case (state)
          ST_IDLE: begin
            if (d_go) begin
              owner_d  <= 1'b1;
              base     <= d_addr_i;
              wdata_q  <= d_wdata_i;
              nbytes_q <= size_bytes(d_size_i);
              mem_a    <= d_addr_i;
              cnt      <= 3'd1;
              asm_q    <= 32'd0;
              if (d_we_i) begin
                state    <= ST_WR;
                mem_wr_q <= 1'b1;
                mem_dout <= d_wdata_i[7:0];
              end else begin
                state <= ST_RD;
              end
            end else if (i_go) begin
              owner_d  <= 1'b0;
              base     <= if_addr_i;
              nbytes_q <= 3'd4;
              mem_a    <= if_addr_i;
              cnt      <= 3'd1;
              asm_q    <= 32'd0;
              state    <= ST_RD;
            end
          end
          ST_RD: begin
            if (!owner_d && flush_i) begin
              state <= ST_IDLE;
              mem_a <= '0;
              cnt   <= 3'd0;
            end else if (!rdy_q) begin
              // Bytes seen around a freeze may be stale, so re-read from byte 0.
              mem_a <= base;
              cnt   <= 3'd1;
              asm_q <= 32'd0;
            end else begin
              if (cnt >= 3'd2) asm_q <= asm_next;
              if (cnt < nbytes_q) mem_a <= base + ADDR_W'(cnt);
              else                mem_a <= '0;
              if (cnt == nbytes_q + 3'd1) begin
                state <= ST_IDLE;
                cnt   <= 3'd0;
                if (owner_d) begin
                  d_done_o  <= 1'b1;
                  d_rdata_o <= asm_next;
                end else begin
                  if_done_o <= 1'b1;
                  if_data_o <= asm_next;
                end
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          ST_WR: begin
            if (cnt < nbytes_q) begin
              mem_a    <= base + ADDR_W'(cnt);
              mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
              cnt      <= cnt + 3'd1;
            end else begin
              state    <= ST_IDLE;
              mem_a    <= '0;
              mem_dout <= 8'd0;
              mem_wr_q <= 1'b0;
              cnt      <= 3'd0;
              d_done_o <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // IO reads have side effects; a freeze would replay them on resume.
  assert property (@(posedge clk) disable iff (rst) io_rd |-> rdy);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_done_o;
  logic [31:0] d_rdata_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  mem [0:1023];
  logic        mem_ready;
  logic        pl_en;
  logic [9:0]  pl_a;
  logic [7:0]  pl_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .IO_BIT(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .if_done_o(if_done_o), .if_data_o(if_data_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // Byte-wide RAM: returns the byte addressed in the previous cycle.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_wr) begin
      mem[mem_a[9:0]] <= mem_dout;
    end
    mem_din <= mem[mem_a[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_a  = a[9:0];
    pl_d  = d;
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  function automatic logic [7:0] peek(input logic [31:0] a);
    return mem[a[9:0]];
  endfunction

  // One transaction from grant (cycle 0) to done; rdy low for cycles [s, s+l).
  task automatic run_txn(input bit fetch, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int s, input int l);
    int n, consumed, p, exp_done, got_done;
    bit restart, stall, store;
    logic [31:0] exp_data;
    n = fetch ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    store = !fetch && we;
    exp_data = 32'd0;
    for (int i = 0; i < n; i++) exp_data[8*i +: 8] = peek(addr + 32'(i));
    if (fetch) begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end else begin
      d_req_i   = 1'b1;
      d_we_i    = we;
      d_size_i  = size;
      d_addr_i  = addr;
      d_wdata_i = wdata;
    end
    consumed = 0; p = 0; restart = 0; exp_done = -1; got_done = -1;
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk);
      #1;
      stall = (l > 0) && (t >= s) && (t < s + l);
      rdy = !stall;
      #1;
      if (stall) begin
        check("stall_wr", 32'(mem_wr), 32'd0);
        restart = 1;
      end else if (store) begin
        if (consumed < n) begin
          check("wr_addr", mem_a, addr + 32'(consumed));
          check("wr_data", 32'(mem_dout), 32'(wdata[8*consumed +: 8]));
          check("wr_en", 32'(mem_wr), 32'd1);
          consumed++;
          if (consumed == n) exp_done = t + 1;
        end
      end else if (restart) begin
        restart = 0;
        p = 0;
      end else begin
        p++;
        if (p <= n) begin
          check("rd_addr", mem_a, addr + 32'(p - 1));
          check("rd_en", 32'(mem_wr), 32'd0);
        end
        if (p == n + 1) exp_done = t + 1;
      end
      if (fetch ? if_done_o : d_done_o) begin
        got_done = t;
        break;
      end
    end
    check(fetch ? "if_done_cycle" : "d_done_cycle", 32'(got_done), 32'(exp_done));
    if (fetch)      check("if_data", if_data_o, exp_data);
    else if (!we)   check("d_rdata", d_rdata_o, exp_data);
    else for (int i = 0; i < n; i++) check("mem_byte", 32'(peek(addr + 32'(i))), 32'(wdata[8*i +: 8]));
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
    rdy      = 1'b1;
    step();
  endtask

  initial begin
    int got;
    logic [7:0] keep;
    rst = 1'b1; rdy = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0; flush_i = 1'b0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = 2'd0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    mem_ready = 1'b0; pl_en = 1'b0; pl_a = 10'd0; pl_d = 8'd0;
    step(); step();
    mem_ready = 1'b1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_if_done", 32'(if_done_o), 32'd0);
    check("rst_d_done", 32'(d_done_o), 32'd0);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_d_rdata", d_rdata_o, 32'd0);
    rst = 1'b0;
    step();

    // Fetch of an addi-nop at 0x100.
    preload(32'h100, 8'h13); preload(32'h101, 8'h00); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    run_txn(1, 0, 2'd2, 32'h100, 32'd0, 0, 0);

    // Store and fetch requested together: the store wins, fetch follows its done.
    d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'd2; d_addr_i = 32'h200; d_wdata_i = 32'hDEADBEEF;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int t = 1; t <= 4; t++) begin
      step();
      check("arb_addr", mem_a, 32'h200 + 32'(t - 1));
      check("arb_wr", 32'(mem_wr), 32'd1);
    end
    step();
    check("arb_d_done", 32'(d_done_o), 32'd1);
    check("arb_byte3", 32'(peek(32'h203)), 32'hDE);
    d_req_i = 1'b0;
    step();
    check("arb_fetch_addr", mem_a, 32'h100);
    got = -1;
    for (int t = 7; t <= 30; t++) begin
      step();
      if (if_done_o) begin got = t; break; end
    end
    check("arb_if_done_cycle", 32'(got), 32'd11);
    check("arb_if_data", if_data_o, 32'h00000013);
    if_req_i = 1'b0;
    step();

    // IO byte load and IO word load.
    preload(32'h30000, 8'h41);
    run_txn(0, 0, 2'd0, 32'h30000, 32'd0, 0, 0);
    check("io_lb_data", d_rdata_o, 32'h00000041);
    run_txn(0, 0, 2'd2, 32'h30004, 32'd0, 0, 0);

    // Freeze in cycles 2-4 of a word load, then address wrap.
    run_txn(0, 0, 2'd2, 32'h300, 32'd0, 2, 3);
    run_txn(0, 0, 2'd2, 32'hFFFFFFFE, 32'd0, 0, 0);
    run_txn(0, 1, 2'd1, 32'hFFFFFFFF, 32'h0000A55A, 1, 2);

    // Flush aborts a fetch; a new fetch is granted the cycle after.
    preload(32'h180, 8'h93); preload(32'h181, 8'h00); preload(32'h182, 8'h10); preload(32'h183, 8'h00);
    if_req_i = 1'b1; if_addr_i = 32'h140;
    step(); step();
    @(posedge clk); #1 flush_i = 1'b1; #1;
    @(posedge clk); #1 flush_i = 1'b0; if_addr_i = 32'h180; #1;
    check("flush_no_done", 32'(if_done_o), 32'd0);
    check("flush_idle_addr", mem_a, 32'd0);
    got = -1;
    for (int t = 5; t <= 30; t++) begin
      step();
      if (t == 5) check("flush_refetch_addr", mem_a, 32'h180);
      if (if_done_o) begin got = t; break; end
    end
    check("flush_if_done_cycle", 32'(got), 32'd10);
    check("flush_if_data", if_data_o, 32'h00100093);
    if_req_i = 1'b0;
    step();

    // Reset in the middle of a word store, after two bytes.
    keep = peek(32'h242);
    d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'd2; d_addr_i = 32'h240; d_wdata_i = 32'h11223344;
    step(); step();
    @(posedge clk); #1 rst = 1'b1; d_req_i = 1'b0; #1;
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_mem_dout", 32'(mem_dout), 32'd0);
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      check("midrst_d_done", 32'(d_done_o), 32'd0);
      check("midrst_idle_wr", 32'(mem_wr), 32'd0);
    end
    check("midrst_byte2", 32'(peek(32'h242)), 32'(keep));
    check("midrst_byte1", 32'(peek(32'h241)), 32'h33);
    run_txn(0, 0, 2'd2, 32'h240, 32'd0, 0, 0);

    // Random mix; bit 17 cleared so freezes never hit the IO region.
    for (int k = 0; k < 40; k++) begin
      bit rf, rw;
      int rs, rl;
      rf = ($urandom % 3) == 0;
      rw = $urandom % 2;
      rs = 1 + int'($urandom % 6);
      rl = ($urandom % 2) ? 1 + int'($urandom % 3) : 0;
      run_txn(rf, rw, 2'($urandom % 4), $urandom & 32'hFFFD_FFFF, $urandom, rs, rl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
